// File: rtl/cpu_pkg.sv
// Shared opcode, flag and bundle definitions for the 16-bit core.
// Imported by every pipeline stage that needs opcode decoding.
package cpu_pkg;

  localparam int DW_DEF = 16;
  localparam int RW_DEF = 4;
  localparam int OPW    = 4;
  localparam int FLGW   = 3;

  localparam logic [OPW-1:0] OP_ADD    = 4'b0000;
  localparam logic [OPW-1:0] OP_SUB    = 4'b0001;
  localparam logic [OPW-1:0] OP_XOR    = 4'b0010;
  localparam logic [OPW-1:0] OP_RED    = 4'b0011;
  localparam logic [OPW-1:0] OP_SLL    = 4'b0100;
  localparam logic [OPW-1:0] OP_SRA    = 4'b0101;
  localparam logic [OPW-1:0] OP_ROR    = 4'b0110;
  localparam logic [OPW-1:0] OP_PADDSB = 4'b0111;
  localparam logic [OPW-1:0] OP_LW     = 4'b1000;
  localparam logic [OPW-1:0] OP_SW     = 4'b1001;
  localparam logic [OPW-1:0] OP_LLB    = 4'b1010;
  localparam logic [OPW-1:0] OP_LHB    = 4'b1011;
  localparam logic [OPW-1:0] OP_B      = 4'b1100;
  localparam logic [OPW-1:0] OP_BR     = 4'b1101;
  localparam logic [OPW-1:0] OP_PCS    = 4'b1110;
  localparam logic [OPW-1:0] OP_HLT    = 4'b1111;

  localparam int FLG_Z = 0;
  localparam int FLG_V = 1;
  localparam int FLG_N = 2;

  typedef logic [FLGW-1:0] flags_t;

  function automatic logic sets_z(
    input logic [OPW-1:0] op
  );
    logic r;
    r = 1'b0;
    unique case (op)
      OP_ADD, OP_SUB, OP_XOR,
      OP_SLL, OP_SRA, OP_ROR: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic sets_nv(
    input logic [OPW-1:0] op
  );
    logic r;
    r = 1'b0;
    unique case (op)
      OP_ADD, OP_SUB: r = 1'b1;
      default:        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ex_mem_flag_stage_flag_next.sv
// Next-state logic for the Z/V/N flag register.
// Purely combinational; the stage decides when to commit it.
module flag_next
  import cpu_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [OPW-1:0] opcode,
  input  logic [DW-1:0]  result,
  input  logic           ovf,
  input  flags_t         flags_q,
  output flags_t         flags_d
);

  logic upd_z;
  logic upd_nv;

  assign upd_z  = sets_z(opcode);
  assign upd_nv = sets_nv(opcode);

  always_comb begin
    flags_d = flags_q;
    if (upd_z) begin
      flags_d[FLG_Z] = (result == '0);
    end
    // ovf is only meaningful from the adder
    if (upd_nv) begin
      flags_d[FLG_N] = result[DW-1];
      flags_d[FLG_V] = ovf;
    end
  end

endmodule

// File: rtl/ex_mem_flag_stage.sv
// EX/MEM pipeline register with architectural flags and sticky halt.
// Priority per edge: rst, flush, stall, load.
module ex_mem_flag_stage
  import cpu_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ex_valid,
  input  logic [3:0]     ex_opcode,
  input  logic [DW-1:0]  ex_result,
  input  logic           ex_ovf,
  input  logic [RW-1:0]  ex_rd,
  input  logic           ex_we,
  input  logic           stall,
  input  logic           flush,
  output logic           mem_valid,
  output logic [3:0]     mem_opcode,
  output logic [DW-1:0]  mem_result,
  output logic [RW-1:0]  mem_rd,
  output logic           mem_we,
  output logic           flag_z,
  output logic           flag_v,
  output logic           flag_n,
  output logic           halted
);

  typedef struct packed {
    logic          valid;
    logic [3:0]    opcode;
    logic [DW-1:0] result;
    logic [RW-1:0] rd;
    logic          we;
  } ex_mem_t;

  ex_mem_t mem_q;
  ex_mem_t mem_ld;
  flags_t  flags_q;
  flags_t  flags_d;
  logic    halted_q;
  logic    load;
  logic    commit;

  flag_next #(.DW(DW)) u_flag_next (
    .opcode  (ex_opcode),
    .result  (ex_result),
    .ovf     (ex_ovf),
    .flags_q (flags_q),
    .flags_d (flags_d)
  );

  assign load   = !flush && !stall;
  assign commit = load && ex_valid;

  always_comb begin
    mem_ld        = '0;
    mem_ld.valid  = ex_valid;
    mem_ld.opcode = ex_opcode;
    mem_ld.result = ex_result;
    mem_ld.rd     = ex_rd;
    // after HLT nothing may retire a register write
    mem_ld.we     = ex_we && ex_valid && !halted_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else if (flush) begin
      mem_q <= '0;
    end else if (!stall) begin
      mem_q <= mem_ld;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q  <= '0;
      halted_q <= 1'b0;
    end else if (commit) begin
      flags_q <= flags_d;
      if (ex_opcode == OP_HLT) begin
        halted_q <= 1'b1;
      end
    end
  end

  assign mem_valid  = mem_q.valid;
  assign mem_opcode = mem_q.opcode;
  assign mem_result = mem_q.result;
  assign mem_rd     = mem_q.rd;
  assign mem_we     = mem_q.we;
  assign flag_z     = flags_q[FLG_Z];
  assign flag_v     = flags_q[FLG_V];
  assign flag_n     = flags_q[FLG_N];
  assign halted     = halted_q;

endmodule
